// File: rtl/red_pitaya_pll_drp_ctrl_if.sv
// DRP bus between the reconfiguration sequencer (master) and the
// PLLE2_ADV dynamic reconfiguration port (slave). DCLK is the sequencer clk.
interface red_pitaya_pll_drp_ctrl_if;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;

    modport master (
        output drp_daddr, drp_den, drp_dwe, drp_di,
        input  drp_do, drp_drdy
    );

    modport slave (
        input  drp_daddr, drp_den, drp_dwe, drp_di,
        output drp_do, drp_drdy
    );
endinterface

// File: rtl/red_pitaya_pll_drp_ctrl.sv
// Run-time divider reconfiguration for the PLLE2_ADV clock generator.
// A request selects one output (CLKOUT0..5 or CLKFBOUT) and an integer
// divide. The sequencer holds the PLL in reset, read-modify-writes the
// output's two DRP registers, releases reset and waits for lock.
module red_pitaya_pll_drp_ctrl #(
    parameter int LOCK_TIMEOUT = 100000,
    parameter int DRDY_TIMEOUT = 64,
    parameter int RST_CYCLES   = 16
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             cfg_start,
    input  logic [2:0]                       cfg_sel,
    input  logic [6:0]                       cfg_div,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic [1:0]                       err_code,
    output logic                             locked,
    red_pitaya_pll_drp_ctrl_if.master        drp,
    output logic                             pll_rst,
    input  logic                             pll_locked
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RST_HOLD,
        ST_RD1,
        ST_RD1_W,
        ST_WR1,
        ST_WR1_W,
        ST_RD2,
        ST_RD2_W,
        ST_WR2,
        ST_WR2_W,
        ST_RELEASE,
        ST_LOCK_W
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_CFG  = 2'd1,
        ERR_DRDY = 2'd2,
        ERR_LOCK = 2'd3
    } err_t;

    // One shared counter serves the reset hold, DRDY wait and lock wait.
    localparam int MAX_AB  = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
    localparam int CNT_MAX = (MAX_AB > RST_CYCLES) ? MAX_AB : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       sel_r;
    logic [6:0]       div_r;
    logic             lock_meta;

    logic             cfg_valid;
    logic [6:0]       addr1;
    logic [6:0]       addr2;
    logic [5:0]       enc_high;
    logic [5:0]       enc_low;
    logic             enc_edge;
    logic             enc_nocnt;
    logic [15:0]      reg1_wr;
    logic [15:0]      reg2_wr;

    // First register of each output's pair; the second is always the next odd address.
    function automatic logic [6:0] reg1_addr(input logic [2:0] sel);
        case (sel)
            3'd0:    reg1_addr = 7'h08;
            3'd1:    reg1_addr = 7'h0A;
            3'd2:    reg1_addr = 7'h0C;
            3'd3:    reg1_addr = 7'h0E;
            3'd4:    reg1_addr = 7'h10;
            3'd5:    reg1_addr = 7'h06;
            default: reg1_addr = 7'h14;
        endcase
    endfunction

    assign cfg_valid = (cfg_sel != 3'd7) && (cfg_div != 7'd0) && (cfg_div <= 7'd64);
    assign addr1     = reg1_addr(sel_r);
    assign addr2     = {addr1[6:1], 1'b1};

    // Divider field encoding and merge with the read-back register contents.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch, so no latch is inferred.
        enc_high  = div_r[6:1];
        // low = D - high always fits in 6 bits (max 32), so the modulo-64 subtract is exact.
        enc_low   = div_r[5:0] - div_r[6:1];
        enc_edge  = div_r[0];
        enc_nocnt = 1'b0;
        if (div_r == 7'd1) begin
            enc_high  = 6'd1;
            enc_low   = 6'd1;
            enc_edge  = 1'b0;
            enc_nocnt = 1'b1;
        end
        reg1_wr = (drp.drp_do & 16'hF000) | {4'h0, enc_high, enc_low};
        reg2_wr = (drp.drp_do & 16'hFF3F) | {8'h00, enc_edge, enc_nocnt, 6'h00};
    end

    // Two-flop synchroniser for the asynchronous PLL LOCKED pin.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_meta <= 1'b0;
            locked    <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
            lock_meta <= pll_locked;
            locked    <= lock_meta;
        end
    end

    // Sequencer FSM with registered status, PLL reset and DRP outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            sel_r         <= '0;
            div_r         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_code      <= ERR_NONE;
            pll_rst       <= 1'b0;
            drp.drp_daddr <= '0;
            drp.drp_den   <= 1'b0;
            drp.drp_dwe   <= 1'b0;
            drp.drp_di    <= '0;
        end else begin
            done        <= 1'b0;
            drp.drp_den <= 1'b0;
            drp.drp_dwe <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        err      <= 1'b0;
                        err_code <= ERR_NONE;
                        if (cfg_valid) begin
                            sel_r   <= cfg_sel;
                            div_r   <= cfg_div;
                            busy    <= 1'b1;
                            pll_rst <= 1'b1;
                            cnt     <= '0;
                            state   <= ST_RST_HOLD;
                        end else begin
                            done     <= 1'b1;
                            err      <= 1'b1;
                            err_code <= ERR_CFG;
                        end
                    end
                end

                ST_RST_HOLD: begin
                    if (cnt == RST_LAST) begin
                        drp.drp_den   <= 1'b1;
                        drp.drp_daddr <= addr1;
                        state         <= ST_RD1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RD1:  begin cnt <= '0; state <= ST_RD1_W; end
                ST_WR1:  begin cnt <= '0; state <= ST_WR1_W; end
                ST_RD2:  begin cnt <= '0; state <= ST_RD2_W; end
                ST_WR2:  begin cnt <= '0; state <= ST_WR2_W; end

                ST_RD1_W, ST_WR1_W, ST_RD2_W, ST_WR2_W: begin
                    if (drp.drp_drdy) begin
                        // Read data is merged on the drdy cycle; the next access issues right after.
                        case (state)
                            ST_RD1_W: begin
                                drp.drp_den <= 1'b1;
                                drp.drp_dwe <= 1'b1;
                                drp.drp_di  <= reg1_wr;
                                state       <= ST_WR1;
                            end
                            ST_WR1_W: begin
                                drp.drp_den   <= 1'b1;
                                drp.drp_daddr <= addr2;
                                state         <= ST_RD2;
                            end
                            ST_RD2_W: begin
                                drp.drp_den <= 1'b1;
                                drp.drp_dwe <= 1'b1;
                                drp.drp_di  <= reg2_wr;
                                state       <= ST_WR2;
                            end
                            default: begin
                                pll_rst <= 1'b0;
                                state   <= ST_RELEASE;
                            end
                        endcase
                    end else if (cnt == DRDY_LAST) begin
                        done     <= 1'b1;
                        err      <= 1'b1;
                        err_code <= ERR_DRDY;
                        busy     <= 1'b0;
                        pll_rst  <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    cnt   <= '0;
                    state <= ST_LOCK_W;
                end

                ST_LOCK_W: begin
                    if (locked) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (cnt == LOCK_LAST) begin
                        done     <= 1'b1;
                        err      <= 1'b1;
                        err_code <= ERR_LOCK;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    pll_rst <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
